// File: rtl/song_sequencer.sv
// song_sequencer
// Prefetches 16-bit song words from memory into a small FIFO, decodes tempo,
// end-of-song and note words, and presents notes to the timing controller
// with a valid/done handshake. Supports play/pause, stop and loop-on-end.
module song_sequencer #(
    parameter int ADDR_W      = 23,
    parameter int FIFO_DEPTH  = 4,
    parameter int START_ADDR  = 0,
    parameter int DEFAULT_BPM = 80
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          PB_PLY,
    input  logic                          STOP,
    input  logic                          LOOP,
    output logic                          MEM_REQ,
    output logic [ADDR_W-1:0]             MEM_ADDR,
    input  logic                          MEM_ACK,
    input  logic [15:0]                   MEM_DATA,
    output logic                          NOTE_VALID,
    output logic [1:0]                    MODE,
    output logic [5:0]                    TONE,
    output logic [3:0]                    NOTE,
    input  logic                          NOTE_DONE,
    output logic [7:0]                    BPM,
    output logic                          PLAY,
    output logic                          END_SONG,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
    localparam logic [7:0]        DEF_BPM   = 8'(DEFAULT_BPM);
    localparam logic [LW-1:0]     DEPTH_LVL = LW'(FIFO_DEPTH);

    typedef enum logic {F_IDLE, F_REQ}  fetch_state_t;
    typedef enum logic {C_POP,  C_NOTE} cons_state_t;

    fetch_state_t  f_state;
    cons_state_t   c_state;

    logic          pb_q;
    logic          pb_rise;
    logic          play_next;
    logic          end_seen;
    logic          discard;

    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [15:0]   head;

    logic          head_bpm;
    logic          head_end;
    logic          data_end;
    logic          pop;
    logic          end_pop;
    logic          flush;
    logic          ack_take;
    logic          ack_drop;
    logic          push;
    logic          fetch_start;

    assign head        = fifo_mem[rd_ptr];
    assign head_bpm    = (head[15:14] == 2'b11) && (head[7:0] != 8'd0);
    assign head_end    = (head[15:14] == 2'b11) && (head[7:0] == 8'd0);
    assign data_end    = (MEM_DATA[15:14] == 2'b11) && (MEM_DATA[7:0] == 8'd0);
    assign pop         = (c_state == C_POP) && PLAY && (FIFO_LEVEL != '0) && !STOP;
    assign end_pop     = pop && head_end;
    assign flush       = STOP || end_pop;
    assign ack_take    = (f_state == F_REQ) && MEM_ACK;
    assign ack_drop    = ack_take && (discard || flush);
    assign push        = ack_take && !ack_drop;
    assign fetch_start = (f_state == F_IDLE) && PLAY && !end_seen && !flush
                         && (FIFO_LEVEL < DEPTH_LVL);
    assign pb_rise     = PB_PLY && !pb_q;

    // Next play state: button edge toggles, stop or a non-looping end wins over the toggle
    always_comb begin
        play_next = PLAY;
        if (pb_rise) begin
            play_next = !PLAY;
        end
        if (STOP || (end_pop && !LOOP)) begin
            play_next = 1'b0;
        end
    end

    // Play state register and button edge history
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pb_q <= 1'b0;
            PLAY <= 1'b0;
        end else begin
            pb_q <= PB_PLY;
            PLAY <= play_next;
        end
    end

    // Fetch FSM: one outstanding request at a time, address held until the ack; a stop or end
    // during a request marks the reply for discarding and the rewind happens when it lands
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            f_state  <= F_IDLE;
            MEM_REQ  <= 1'b0;
            MEM_ADDR <= START_A;
            end_seen <= 1'b0;
            discard  <= 1'b0;
        end else if (f_state == F_IDLE) begin
            if (flush) begin
                MEM_ADDR <= START_A;
                end_seen <= 1'b0;
            end else if (fetch_start) begin
                f_state <= F_REQ;
                MEM_REQ <= 1'b1;
            end
        end else begin
            if (ack_drop) begin
                MEM_ADDR <= START_A;
                discard  <= 1'b0;
                end_seen <= 1'b0;
                f_state  <= F_IDLE;
                MEM_REQ  <= 1'b0;
            end else if (ack_take) begin
                MEM_ADDR <= MEM_ADDR + ADDR_W'(1);
                if (data_end) begin
                    end_seen <= 1'b1;
                end
                f_state <= F_IDLE;
                MEM_REQ <= 1'b0;
            end else if (flush) begin
                discard  <= 1'b1;
                end_seen <= 1'b0;
            end
        end
    end

    // Prefetch FIFO storage; words land only on an accepted ack
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= MEM_DATA;
        end
    end

    // FIFO pointers and level; stop and end-of-song empty it in one cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                FIFO_LEVEL <= FIFO_LEVEL + LW'(1);
            end else if (!push && pop) begin
                FIFO_LEVEL <= FIFO_LEVEL - LW'(1);
            end
        end
    end

    // Consumer FSM: tempo words apply at one per cycle, notes are held until done, pause masks valid
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            c_state    <= C_POP;
            NOTE_VALID <= 1'b0;
            MODE       <= 2'd0;
            TONE       <= 6'd0;
            NOTE       <= 4'd0;
            BPM        <= DEF_BPM;
            END_SONG   <= 1'b0;
        end else begin
            END_SONG <= 1'b0;
            if (STOP) begin
                NOTE_VALID <= 1'b0;
                c_state    <= C_POP;
                BPM        <= DEF_BPM;
            end else if (c_state == C_POP) begin
                NOTE_VALID <= 1'b0;
                if (pop) begin
                    if (head_end) begin
                        END_SONG <= 1'b1;
                        BPM      <= DEF_BPM;
                    end else if (head_bpm) begin
                        BPM <= head[7:0];
                    end else begin
                        MODE       <= head[15:14];
                        TONE       <= head[13:8];
                        NOTE       <= head[3:0];
                        NOTE_VALID <= play_next;
                        c_state    <= C_NOTE;
                    end
                end
            end else begin
                if (NOTE_VALID && NOTE_DONE) begin
                    NOTE_VALID <= 1'b0;
                    c_state    <= C_POP;
                end else begin
                    NOTE_VALID <= play_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer
// Directed scenarios for song_sequencer with a small song ROM behind a
// req/ack memory responder that can withhold the ack for a chosen address.
`timescale 1ns/1ps
module tb_song_sequencer;

    localparam int ADDR_W = 23;

    logic              CLK;
    logic              RST_N;
    logic              PB_PLY;
    logic              STOP;
    logic              LOOP;
    logic              MEM_REQ;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_ACK;
    logic [15:0]       MEM_DATA;
    logic              NOTE_VALID;
    logic [1:0]        MODE;
    logic [5:0]        TONE;
    logic [3:0]        NOTE;
    logic              NOTE_DONE;
    logic [7:0]        BPM;
    logic              PLAY;
    logic              END_SONG;
    logic [2:0]        FIFO_LEVEL;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] rom [16];
    logic [3:0]  hold_addr;
    int          fetch_log [64];
    int          log_n = 0;

    song_sequencer #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .START_ADDR(0), .DEFAULT_BPM(80)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .PB_PLY(PB_PLY), .STOP(STOP), .LOOP(LOOP),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
        .NOTE_VALID(NOTE_VALID), .MODE(MODE), .TONE(TONE), .NOTE(NOTE),
        .NOTE_DONE(NOTE_DONE), .BPM(BPM), .PLAY(PLAY), .END_SONG(END_SONG),
        .FIFO_LEVEL(FIFO_LEVEL)
    );

    // 100 MHz clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory responder: acks one cycle after a request unless the address is held
    initial begin
        MEM_ACK  = 1'b0;
        MEM_DATA = 16'h0000;
        forever begin
            @(negedge CLK);
            if (MEM_ACK) begin
                MEM_ACK = 1'b0;
            end else if (MEM_REQ && (MEM_ADDR[3:0] != hold_addr)) begin
                MEM_DATA = rom[MEM_ADDR[3:0]];
                MEM_ACK  = 1'b1;
                if (log_n < 64) begin
                    fetch_log[log_n] = int'(MEM_ADDR);
                    log_n++;
                end
            end
        end
    end

    task automatic press_play;
        PB_PLY = 1'b1;
        repeat (2) @(negedge CLK);
        PB_PLY = 1'b0;
        @(negedge CLK);
    endtask

    task automatic pulse_stop;
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
    endtask

    task automatic pulse_done;
        NOTE_DONE = 1'b1;
        @(negedge CLK);
        NOTE_DONE = 1'b0;
    endtask

    task automatic wait_nv(input int budget, output bit ok);
        int n = 0;
        while (!NOTE_VALID && n < budget) begin
            @(negedge CLK);
            n++;
        end
        ok = (NOTE_VALID === 1'b1);
    endtask

    task automatic wait_req_at(input int addr, input int budget, output bit ok);
        int n = 0;
        while (!(MEM_REQ === 1'b1 && int'(MEM_ADDR) == addr) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        ok = (MEM_REQ === 1'b1) && (int'(MEM_ADDR) == addr);
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (PLAY !== 1'b0) begin errors++; $display("[TB] FAIL reset_play: got %0b expected 0", PLAY); end
        checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b expected 0", MEM_REQ); end
        checks++; if (MEM_ADDR !== 23'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0h expected 0", MEM_ADDR); end
        checks++; if (NOTE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", NOTE_VALID); end
        checks++; if ({MODE, TONE, NOTE} !== 12'h000) begin errors++; $display("[TB] FAIL reset_note: got %0h expected 0", {MODE, TONE, NOTE}); end
        checks++; if (BPM !== 8'd80) begin errors++; $display("[TB] FAIL reset_bpm: got %0d expected 80", BPM); end
        checks++; if (END_SONG !== 1'b0) begin errors++; $display("[TB] FAIL reset_end: got %0b expected 0", END_SONG); end
        checks++; if (FIFO_LEVEL !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", FIFO_LEVEL); end
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_first_note;
        bit ok;
        press_play;
        checks++; if (PLAY !== 1'b1) begin errors++; $display("[TB] FAIL play_toggle: got %0b expected 1", PLAY); end
        wait_nv(40, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL first_note_timeout: got valid=%0b expected 1", NOTE_VALID); end
        checks++; if ({MODE, TONE, NOTE} !== {2'd0, 6'd1, 4'd3}) begin errors++; $display("[TB] FAIL first_note: got mode=%0d tone=%0d note=%0d expected 0/1/3", MODE, TONE, NOTE); end
        checks++; if (BPM !== 8'd120) begin errors++; $display("[TB] FAIL first_bpm: got %0d expected 120", BPM); end
        checks++; if (!(log_n >= 2 && fetch_log[0] == 0 && fetch_log[1] == 1)) begin errors++; $display("[TB] FAIL fetch_order: got n=%0d a0=%0d a1=%0d expected 0,1", log_n, fetch_log[0], fetch_log[1]); end
    endtask

    task automatic test_note_done;
        repeat (10) @(negedge CLK);
        checks++; if (FIFO_LEVEL !== 3'd2) begin errors++; $display("[TB] FAIL prefetch_level: got %0d expected 2", FIFO_LEVEL); end
        checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("[TB] FAIL req_after_end_word: got %0b expected 0", MEM_REQ); end
        NOTE_DONE = 1'b1;
        @(negedge CLK);
        NOTE_DONE = 1'b0;
        checks++; if (NOTE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL done_gap: got %0b expected 0", NOTE_VALID); end
        @(negedge CLK);
        checks++; if (NOTE_VALID !== 1'b1) begin errors++; $display("[TB] FAIL second_valid: got %0b expected 1", NOTE_VALID); end
        checks++; if ({MODE, TONE, NOTE} !== {2'd1, 6'd2, 4'd5}) begin errors++; $display("[TB] FAIL second_note: got mode=%0d tone=%0d note=%0d expected 1/2/5", MODE, TONE, NOTE); end
        checks++; if (FIFO_LEVEL !== 3'd1) begin errors++; $display("[TB] FAIL second_level: got %0d expected 1", FIFO_LEVEL); end
    endtask

    task automatic test_end_no_loop;
        bit req_quiet = 1'b1;
        LOOP = 1'b0;
        pulse_done;
        @(negedge CLK);
        checks++; if (END_SONG !== 1'b1) begin errors++; $display("[TB] FAIL end_pulse: got %0b expected 1", END_SONG); end
        checks++; if (PLAY !== 1'b0) begin errors++; $display("[TB] FAIL end_play: got %0b expected 0", PLAY); end
        checks++; if (BPM !== 8'd80) begin errors++; $display("[TB] FAIL end_bpm: got %0d expected 80", BPM); end
        checks++; if (MEM_ADDR !== 23'd0) begin errors++; $display("[TB] FAIL end_addr: got %0h expected 0", MEM_ADDR); end
        checks++; if (FIFO_LEVEL !== 3'd0) begin errors++; $display("[TB] FAIL end_level: got %0d expected 0", FIFO_LEVEL); end
        @(negedge CLK);
        checks++; if (END_SONG !== 1'b0) begin errors++; $display("[TB] FAIL end_one_cycle: got %0b expected 0", END_SONG); end
        repeat (10) begin
            @(negedge CLK);
            if (MEM_REQ !== 1'b0) req_quiet = 1'b0;
        end
        checks++; if (!req_quiet) begin errors++; $display("[TB] FAIL end_req_quiet: got req seen expected none"); end
    endtask

    task automatic test_end_loop;
        bit ok;
        int n = 0;
        LOOP = 1'b1;
        press_play;
        wait_nv(40, ok);
        checks++; if (!ok || TONE !== 6'd1) begin errors++; $display("[TB] FAIL loop_first: got valid=%0b tone=%0d expected 1/1", NOTE_VALID, TONE); end
        repeat (10) @(negedge CLK);
        pulse_done;
        wait_nv(20, ok);
        checks++; if (!ok || TONE !== 6'd2) begin errors++; $display("[TB] FAIL loop_second: got valid=%0b tone=%0d expected 1/2", NOTE_VALID, TONE); end
        pulse_done;
        while (END_SONG !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++; if (END_SONG !== 1'b1) begin errors++; $display("[TB] FAIL loop_end_timeout: got %0b expected 1", END_SONG); end
        checks++; if (PLAY !== 1'b1 || BPM !== 8'd80) begin errors++; $display("[TB] FAIL loop_end_state: got play=%0b bpm=%0d expected 1/80", PLAY, BPM); end
        wait_req_at(0, 10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL loop_refetch: got req=%0b addr=%0h expected 1/0", MEM_REQ, MEM_ADDR); end
        wait_nv(40, ok);
        checks++; if (!ok || TONE !== 6'd1 || NOTE !== 4'd3 || BPM !== 8'd120) begin errors++; $display("[TB] FAIL loop_replay: got tone=%0d note=%0d bpm=%0d expected 1/3/120", TONE, NOTE, BPM); end
    endtask

    task automatic test_stop_idle;
        LOOP = 1'b0;
        pulse_stop;
        repeat (4) @(negedge CLK);
        checks++; if (PLAY !== 1'b0 || NOTE_VALID !== 1'b0 || MEM_REQ !== 1'b0) begin errors++; $display("[TB] FAIL stop_outputs: got play=%0b valid=%0b req=%0b expected 0/0/0", PLAY, NOTE_VALID, MEM_REQ); end
        checks++; if (FIFO_LEVEL !== 3'd0 || MEM_ADDR !== 23'd0 || BPM !== 8'd80) begin errors++; $display("[TB] FAIL stop_state: got level=%0d addr=%0h bpm=%0d expected 0/0/80", FIFO_LEVEL, MEM_ADDR, BPM); end
    endtask

    task automatic test_ack_withheld;
        bit ok;
        bit held = 1'b1;
        bit rest = 1'b1;
        hold_addr = 4'd2;
        press_play;
        wait_nv(40, ok);
        checks++; if (!ok || TONE !== 6'd1) begin errors++; $display("[TB] FAIL hold_first: got valid=%0b tone=%0d expected 1/1", NOTE_VALID, TONE); end
        wait_req_at(2, 20, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_req: got req=%0b addr=%0h expected 1/2", MEM_REQ, MEM_ADDR); end
        pulse_done;
        repeat (20) begin
            @(negedge CLK);
            if (MEM_REQ !== 1'b1 || MEM_ADDR !== 23'd2) held = 1'b0;
            if (NOTE_VALID !== 1'b0) rest = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("[TB] FAIL hold_stable: got req=%0b addr=%0h expected held 1/2", MEM_REQ, MEM_ADDR); end
        checks++; if (!rest) begin errors++; $display("[TB] FAIL underflow_rest: got valid seen expected 0"); end
        checks++; if (FIFO_LEVEL !== 3'd0 || PLAY !== 1'b1) begin errors++; $display("[TB] FAIL underflow_state: got level=%0d play=%0b expected 0/1", FIFO_LEVEL, PLAY); end
        hold_addr = 4'hF;
        wait_nv(20, ok);
        checks++; if (!ok || {MODE, TONE, NOTE} !== {2'd1, 6'd2, 4'd5}) begin errors++; $display("[TB] FAIL hold_resume: got valid=%0b mode=%0d tone=%0d note=%0d expected 1/1/2/5", NOTE_VALID, MODE, TONE, NOTE); end
    endtask

    task automatic test_stop_discard;
        bit ok;
        bit no_end = 1'b1;
        pulse_stop;
        repeat (4) @(negedge CLK);
        hold_addr = 4'd1;
        press_play;
        wait_req_at(1, 20, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL discard_req: got req=%0b addr=%0h expected 1/1", MEM_REQ, MEM_ADDR); end
        pulse_stop;
        checks++; if (MEM_REQ !== 1'b1 || PLAY !== 1'b0) begin errors++; $display("[TB] FAIL stop_req_held: got req=%0b play=%0b expected 1/0", MEM_REQ, PLAY); end
        repeat (3) begin
            @(negedge CLK);
            if (END_SONG !== 1'b0) no_end = 1'b0;
        end
        hold_addr = 4'hF;
        repeat (5) begin
            @(negedge CLK);
            if (END_SONG !== 1'b0) no_end = 1'b0;
        end
        checks++; if (!no_end) begin errors++; $display("[TB] FAIL stop_no_end: got pulse expected none"); end
        checks++; if (FIFO_LEVEL !== 3'd0 || MEM_ADDR !== 23'd0) begin errors++; $display("[TB] FAIL discard_word: got level=%0d addr=%0h expected 0/0", FIFO_LEVEL, MEM_ADDR); end
        checks++; if (PLAY !== 1'b0 || MEM_REQ !== 1'b0 || NOTE_VALID !== 1'b0 || BPM !== 8'd80) begin errors++; $display("[TB] FAIL discard_state: got play=%0b req=%0b valid=%0b bpm=%0d expected 0/0/0/80", PLAY, MEM_REQ, NOTE_VALID, BPM); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int start_n;
        start_n = log_n;
        press_play;
        wait_nv(40, ok);
        checks++; if (!ok || TONE !== 6'd1 || BPM !== 8'd120) begin errors++; $display("[TB] FAIL restart_note: got valid=%0b tone=%0d bpm=%0d expected 1/1/120", NOTE_VALID, TONE, BPM); end
        checks++; if (!(log_n > start_n && fetch_log[start_n] == 0)) begin errors++; $display("[TB] FAIL restart_addr: got n=%0d first=%0d expected addr 0", log_n - start_n, fetch_log[start_n]); end
    endtask

    // Scenario sequence
    initial begin
        RST_N     = 1'b0;
        PB_PLY    = 1'b0;
        STOP      = 1'b0;
        LOOP      = 1'b0;
        NOTE_DONE = 1'b0;
        hold_addr = 4'hF;
        for (int i = 0; i < 16; i++) rom[i] = 16'hC000;
        rom[0] = 16'hC078;
        rom[1] = 16'h0103;
        rom[2] = 16'h4205;
        rom[3] = 16'hC000;
        test_reset;
        test_first_note;
        test_note_done;
        test_end_no_loop;
        test_end_loop;
        test_stop_idle;
        test_ack_withheld;
        test_stop_discard;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
